typing_countdown_timer: RTL

//   Countdown timer for the typing test. Consumes the 1 Hz one-cycle tick and the

---
 rtl/typing_countdown_timer_if.sv | 25 ++
 rtl/typing_countdown_timer.sv | 106 ++++++++++
 2 files changed

// File: rtl/typing_countdown_timer_if.sv
// typing_countdown_timer_if: control inputs, BCD count and 7-seg drive of the countdown timer
interface typing_countdown_timer_if;
  logic       sec_tick;
  logic       scan_clk;
  logic       start;
  logic       pause;
  logic       running;
  logic       done;
  logic       expired;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  modport master (
    output sec_tick, scan_clk, start, pause,
    input  running, done, expired, min_tens, min_ones, sec_tens, sec_ones, an, seg, dp
  );
  modport slave (
    input  sec_tick, scan_clk, start, pause,
    output running, done, expired, min_tens, min_ones, sec_tens, sec_ones, an, seg, dp
  );
endinterface

// File: rtl/typing_countdown_timer.sv
// typing_countdown_timer: BCD MM:SS countdown with start/pause FSM and multiplexed 7-seg display
module typing_countdown_timer #(
  parameter int START_MIN = 1,
  parameter int START_SEC = 0
) (
  input logic clk,
  input logic rst,
  typing_countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;
  localparam logic [3:0] R_MT = 4'(START_MIN / 10);
  localparam logic [3:0] R_MO = 4'(START_MIN % 10);
  localparam logic [3:0] R_ST = 4'(START_SEC / 10);
  localparam logic [3:0] R_SO = 4'(START_SEC % 10);
  state_t state, state_n;
  logic [3:0] mt, mo, st, so, mt_n, mo_n, st_n, so_n, cur, an, an_n;
  logic [6:0] seg, seg_n;
  logic [1:0] idx;
  logic done, done_n, running, expired, dp, dp_n, scan_r, scan_p, rise, zero, last;
  assign zero = {mt, mo, st, so} == 16'h0000;
  assign last = {mt, mo, st, so} == 16'h0001;
  always_comb begin
    state_n = state;
    {mt_n, mo_n, st_n, so_n} = {mt, mo, st, so};
    done_n = 1'b0;
    if (bus.pause) begin
      state_n = state == RUNNING ? PAUSED : state;
    end else if (bus.start) begin
      if (state == IDLE) begin
        state_n = zero ? DONE : RUNNING;
        done_n = zero;
      end else if (state == PAUSED) begin
        state_n = RUNNING;
      end else if (state == DONE) begin
        state_n = RUNNING;
        {mt_n, mo_n, st_n, so_n} = {R_MT, R_MO, R_ST, R_SO};
      end
    end else if (bus.sec_tick && state == RUNNING && !zero) begin
      so_n = so == 4'd0 ? 4'd9 : so - 4'd1;
      st_n = so != 4'd0 ? st : st == 4'd0 ? 4'd5 : st - 4'd1;
      mo_n = {so, st} != 8'h00 ? mo : mo == 4'd0 ? 4'd9 : mo - 4'd1;
      mt_n = {so, st, mo} != 12'h000 ? mt : mt - 4'd1;
      state_n = last ? DONE : RUNNING;
      done_n = last;
    end
  end
  // The display latches the digit at the current index, then the index moves on.
  assign rise = scan_r & ~scan_p;
  always_comb begin
    cur = idx == 2'd0 ? so : idx == 2'd1 ? st : idx == 2'd2 ? mo : mt;
    an_n = ~(4'b0001 << idx);
    dp_n = idx != 2'd2;
    case (cur)
      4'd0:    seg_n = 7'b1000000;
      4'd1:    seg_n = 7'b1111001;
      4'd2:    seg_n = 7'b0100100;
      4'd3:    seg_n = 7'b0110000;
      4'd4:    seg_n = 7'b0011001;
      4'd5:    seg_n = 7'b0010010;
      4'd6:    seg_n = 7'b0000010;
      4'd7:    seg_n = 7'b1111000;
      4'd8:    seg_n = 7'b0000000;
      4'd9:    seg_n = 7'b0010000;
      default: seg_n = 7'h7F;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {mt, mo, st, so} <= {R_MT, R_MO, R_ST, R_SO};
      running <= 1'b0;
      done <= 1'b0;
      expired <= 1'b0;
      scan_r <= 1'b0;
      scan_p <= 1'b0;
      idx <= 2'd0;
      an <= 4'hF;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      state <= state_n;
      {mt, mo, st, so} <= {mt_n, mo_n, st_n, so_n};
      running <= state_n == RUNNING;
      done <= done_n;
      expired <= state_n == DONE;
      scan_r <= bus.scan_clk;
      scan_p <= scan_r;
      if (rise) begin
        idx <= idx + 2'd1;
        an <= an_n;
        seg <= seg_n;
        dp <= dp_n;
      end
    end
  end
  assign bus.running = running;
  assign bus.done = done;
  assign bus.expired = expired;
  assign bus.min_tens = mt;
  assign bus.min_ones = mo;
  assign bus.sec_tens = st;
  assign bus.sec_ones = so;
  assign bus.an = an;
  assign bus.seg = seg;
  assign bus.dp = dp;
endmodule
